// File: rtl/beam_scan_controller.sv
// Steps the beamformer delay_select through every steering direction, integrates
// |beam sum| over a fixed number of frames per direction, and locks onto the loudest one.
module beam_scan_controller #(
  parameter int NUM_DIRS   = 16,
  parameter int DWELL_LOG2 = 4,
  parameter int SETTLE     = 2,
  parameter int ACC_W      = 22 + DWELL_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lr_clk,
  input  logic [21:0]       sum_in,
  input  logic              start,
  input  logic              manual_en,
  input  logic [4:0]        manual_dir,
  output logic [4:0]        delay_select,
  output logic [4:0]        best_dir,
  output logic [ACC_W-1:0]  best_energy,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_ACCUM   = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_LOCK    = 3'd4;

  localparam int             FRAME_W     = DWELL_LOG2 + 1;
  localparam logic [4:0]     LAST_DIR    = 5'(NUM_DIRS - 1);
  localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [FRAME_W-1:0] DWELL_LAST = FRAME_W'((1 << DWELL_LOG2) - 1);

  logic [2:0]         state;
  logic               lr_q;
  logic               tick;
  logic [4:0]         dir;
  logic [3:0]         settle_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic [ACC_W-1:0]   acc;
  logic [21:0]        energy;
  logic               better;
  logic [4:0]         win_dir;

  assign tick = lr_clk & ~lr_q;

  // NOTE: magnitude is kept at 22 bits unsigned so -2^21 becomes 2^21 instead of wrapping.
  assign energy = sum_in[21] ? (~sum_in + 22'd1) : sum_in;

  // The first direction always seeds the best; strict compare keeps the lower index on ties.
  assign better  = (acc > best_energy) || (dir == 5'd0);
  assign win_dir = better ? dir : best_dir;

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      lr_q         <= 1'b0;
      dir          <= 5'd0;
      settle_cnt   <= 4'd0;
      frame_cnt    <= '0;
      acc          <= '0;
      delay_select <= 5'd0;
      best_dir     <= 5'd0;
      best_energy  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      lr_q <= lr_clk;
      done <= 1'b0;
      case (state)
        S_IDLE, S_LOCK: begin
          if (manual_en) begin
            delay_select <= manual_dir;
          end else if (start) begin
            dir          <= 5'd0;
            delay_select <= 5'd0;
            best_energy  <= '0;
            best_dir     <= 5'd0;
            busy         <= 1'b1;
            settle_cnt   <= 4'd0;
            state        <= S_SETTLE;
          end else if (state == S_LOCK) begin
            delay_select <= best_dir;
          end
        end

        S_SETTLE: begin
          if (SETTLE == 0) begin
            acc       <= '0;
            frame_cnt <= '0;
            state     <= S_ACCUM;
          end else if (tick) begin
            if (settle_cnt == SETTLE_LAST) begin
              acc       <= '0;
              frame_cnt <= '0;
              state     <= S_ACCUM;
            end else begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
        end

        S_ACCUM: begin
          if (tick) begin
            acc       <= acc + ACC_W'(energy);
            frame_cnt <= frame_cnt + FRAME_W'(1);
            if (frame_cnt == DWELL_LAST) state <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          if (better) begin
            best_energy <= acc;
            best_dir    <= dir;
          end
          if (dir == LAST_DIR) begin
            done         <= 1'b1;
            busy         <= 1'b0;
            delay_select <= win_dir;
            state        <= S_LOCK;
          end else begin
            dir          <= dir + 5'd1;
            delay_select <= dir + 5'd1;
            settle_cnt   <= 4'd0;
            state        <= S_SETTLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beam_scan_controller.sv
// Directed scenarios for beam_scan_controller; expected scan results are queued at
// start and matched by a monitor whenever done pulses.
module tb_beam_scan_controller;

  localparam int NUM_DIRS   = 4;
  localparam int DWELL_LOG2 = 2;
  localparam int SETTLE     = 1;
  localparam int ACC_W      = 24;
  localparam int SCAN_TICKS = NUM_DIRS * (SETTLE + (1 << DWELL_LOG2));

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              lr_clk = 1'b0;
  logic [21:0]       sum_in = '0;
  logic              start = 1'b0;
  logic              manual_en = 1'b0;
  logic [4:0]        manual_dir = '0;
  logic [4:0]        delay_select;
  logic [4:0]        best_dir;
  logic [ACC_W-1:0]  best_energy;
  logic              busy;
  logic              done;

  beam_scan_controller #(
    .NUM_DIRS(NUM_DIRS), .DWELL_LOG2(DWELL_LOG2), .SETTLE(SETTLE), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .lr_clk(lr_clk), .sum_in(sum_in), .start(start),
    .manual_en(manual_en), .manual_dir(manual_dir), .delay_select(delay_select),
    .best_dir(best_dir), .best_energy(best_energy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]       dir;
    logic [ACC_W-1:0] energy;
    int               ticks;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          tick_cnt = 0;
  int          busy_gap = 0;
  int          phase = 0;
  logic        scan_active = 1'b0;
  logic        settle_mode = 1'b0;
  logic        armed = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_done = 1'b0;
  logic [4:0]  prev_ds = '0;
  logic [21:0] sum_tab [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic set_tab(input int a, input int b, input int c, input int d);
    sum_tab[0] = 22'(a);
    sum_tab[1] = 22'(b);
    sum_tab[2] = 22'(c);
    sum_tab[3] = 22'(d);
  endtask

  // Frame generator: lr_clk period of 8 clk cycles; beam sum follows the steered direction,
  // or in settle mode carries a large value only on the first tick after a direction change.
  initial begin
    forever begin
      @(negedge clk);
      if ((busy && !prev_busy) || (delay_select != prev_ds)) armed = 1'b1;
      prev_busy = busy;
      prev_ds   = delay_select;
      phase     = (phase + 1) % 8;
      if (phase == 0) begin
        tick_cnt++;
        if (settle_mode) begin
          sum_in = armed ? 22'd10000 : 22'd0;
          armed  = 1'b0;
        end else begin
          sum_in = sum_tab[delay_select[1:0]];
        end
        lr_clk = 1'b1;
      end else if (phase == 4) begin
        lr_clk = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_done) check("done_pulse_width", 32'(done), 32'd0);
      prev_done = done;
      if (scan_active && !busy && !done) busy_gap++;
      if (done) begin
        scan_active = 1'b0;
        check("busy_low_at_done", 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending scan");
        end else begin
          e = exp_q.pop_front();
          check("best_dir", 32'(best_dir), 32'(e.dir));
          check("best_energy", 32'(best_energy), 32'(e.energy));
          check("delay_select_at_done", 32'(delay_select), 32'(e.dir));
          check("scan_ticks", 32'(tick_cnt), 32'(e.ticks));
          check("busy_whole_scan_gaps", 32'(busy_gap), 32'd0);
        end
      end
    end
  end

  task automatic start_scan(input logic push, input logic [4:0] d, input logic [ACC_W-1:0] en);
    @(negedge lr_clk);
    armed    = 1'b0;
    tick_cnt = 0;
    busy_gap = 0;
    if (push) exp_q.push_back('{dir: d, energy: en, ticks: SCAN_TICKS});
    start = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    scan_active = 1'b1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: got no done after %0d cycles expected done", n);
      exp_q.delete();
      scan_active = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_delay_select"}, 32'(delay_select), 32'd0);
    check({tag, "_best_dir"}, 32'(best_dir), 32'd0);
    check({tag, "_best_energy"}, 32'(best_energy), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    set_tab(100, -500, 300, 200);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("por");

    // Abort a scan partway through with a two-cycle reset
    start_scan(1'b0, 5'd0, '0);
    repeat (60) @(negedge clk);
    check("busy_mid_scan", 32'(busy), 32'd1);
    check("best_energy_mid_scan", 32'(best_energy), 32'd400);
    scan_active = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("abort");
    repeat (20) @(negedge clk);
    check("idle_after_abort_busy", 32'(busy), 32'd0);
    check("idle_after_abort_ds", 32'(delay_select), 32'd0);

    // Basic scan: dir1 (|-500|*4) wins
    start_scan(1'b1, 5'd1, 24'd2000);
    wait_done();

    // Extra start pulses during a scan must not restart it
    start_scan(1'b1, 5'd1, 24'd2000);
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (70) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Manual override from LOCK with best_dir=1
    manual_en  = 1'b1;
    manual_dir = 5'd7;
    @(negedge clk);
    check("manual_ds", 32'(delay_select), 32'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("manual_start_ignored_busy", 32'(busy), 32'd0);
    check("manual_start_ignored_ds", 32'(delay_select), 32'd7);
    manual_en = 1'b0;
    @(negedge clk);
    check("manual_release_ds", 32'(delay_select), 32'd1);
    check("manual_best_dir_kept", 32'(best_dir), 32'd1);

    // Tie: dir0 and dir2 both 1200, lower index wins
    set_tab(300, 0, -300, 0);
    start_scan(1'b1, 5'd0, 24'd1200);
    wait_done();

    // Most negative sample on every direction: 4 * 2^21 with no wrap
    set_tab(-2097152, -2097152, -2097152, -2097152);
    start_scan(1'b1, 5'd0, 24'd8388608);
    wait_done();

    // Only the settle frame carries energy, so every accumulator stays 0
    settle_mode = 1'b1;
    start_scan(1'b1, 5'd0, 24'd0);
    wait_done();
    settle_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
